// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, registers ROM data and hands {instruction, PC}
// to decode over valid/ready, with branch redirect, start and halt handling.
module inst_fetch #(
    parameter int unsigned    IW         = 10,
    parameter int unsigned    DW         = 9,
    parameter logic [DW-1:0]  HALT_OP    = 9'b111111111,
    parameter logic [IW-1:0]  START_ADDR = '0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    output logic [IW-1:0] InstAddress,
    input  logic [DW-1:0] InstIn,
    output logic [DW-1:0] InstOut,
    output logic [IW-1:0] PCOut,
    output logic          Valid,
    input  logic          Ready,
    input  logic          BranchEn,
    input  logic          BranchRel,
    input  logic [IW-1:0] BranchBase,
    input  logic [IW-1:0] Target,
    output logic          Done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StHalt} state_e;

    localparam logic [IW-1:0] PcOne = 1;

    state_e        state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [DW-1:0] inst_q, inst_d;
    logic [IW-1:0] pc_out_q, pc_out_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          adv;
    logic [IW-1:0] branch_target;

    assign adv           = !valid_q || Ready;
    // Sum wraps modulo 2**IW; a negative offset is plain two's complement.
    assign branch_target = BranchRel ? (BranchBase + Target) : Target;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        done_d   = done_q;
        unique case (state_q)
            StIdle, StHalt: begin
                if (Start) begin
                    pc_d    = START_ADDR;
                    done_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (BranchEn) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                end else if (adv) begin
                    inst_d   = InstIn;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    if (InstIn == HALT_OP) begin
                        state_d = StDrain;
                    end else begin
                        pc_d = pc_q + PcOne;
                    end
                end
            end
            StDrain: begin
                if (BranchEn) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                    state_d = StRun;
                end else if (valid_q && Ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = StHalt;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= StIdle;
            pc_q     <= START_ADDR;
            inst_q   <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign InstAddress = pc_q;
    assign InstOut     = inst_q;
    assign PCOut       = pc_out_q;
    assign Valid       = valid_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed programs push expected {inst, pc} pairs,
// a negedge monitor pops and compares on every accepted handshake.
module tb_inst_fetch;

    localparam logic [8:0] HALT = 9'h1FF;

    logic       Clk, Reset, Start, Ready, BranchEn, BranchRel, Valid, Done;
    logic [9:0] InstAddress, PCOut, BranchBase, Target;
    logic [8:0] InstIn, InstOut;
    logic [8:0] rom [0:1023];

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q [$];

    inst_fetch dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .InstAddress(InstAddress),
        .InstIn     (InstIn),
        .InstOut    (InstOut),
        .PCOut      (PCOut),
        .Valid      (Valid),
        .Ready      (Ready),
        .BranchEn   (BranchEn),
        .BranchRel  (BranchRel),
        .BranchBase (BranchBase),
        .Target     (Target),
        .Done       (Done)
    );

    assign InstIn = rom[InstAddress];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(negedge Clk) begin
        if (Reset && Valid && Ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL handshake_unexpected got inst=%0d pc=%0d want none",
                         InstOut, PCOut);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({InstOut, PCOut} !== e) begin
                    errors++;
                    $display("FAIL handshake got inst=%0d pc=%0d want inst=%0d pc=%0d",
                             InstOut, PCOut, e[18:10], e[9:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic push(input logic [8:0] inst, input logic [9:0] pc);
        exp_q.push_back({inst, pc});
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!Done && n < 30) begin
            tick();
            n++;
        end
        chk({name, "_done"}, Done, 1);
        tick();
        chk({name, "_valid_after"}, Valid, 0);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic seq_program();
        push(9'd1, 10'd0); push(9'd2, 10'd1); push(9'd3, 10'd2); push(HALT, 10'd3);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'd0;
        rom[0] = 9'd1; rom[1] = 9'd2; rom[2] = 9'd3; rom[3] = HALT;
        rom[10] = 9'd55; rom[11] = HALT; rom[1023] = 9'd7;
        Reset = 1'b0; Start = 1'b0; Ready = 1'b1; BranchEn = 1'b0; BranchRel = 1'b0;
        BranchBase = '0; Target = '0;
        #12;
        chk("reset_valid", Valid, 0);
        chk("reset_done", Done, 0);
        chk("reset_pc", InstAddress, 0);
        chk("reset_instout", InstOut, 0);
        tick();
        Reset = 1'b1;
        tick();
        tick();
        chk("idle_no_fetch", Valid, 0);

        // Sequential fetch
        seq_program();
        pulse_start();
        chk("seq_lat_valid0", Valid, 0);
        chk("seq_lat_pc", InstAddress, 0);
        tick();
        chk("seq_first_valid", Valid, 1);
        wait_done("seq");

        // Backpressure while {2,1} is presented
        seq_program();
        pulse_start();
        tick();
        tick();
        Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_inst", InstOut, 2);
            chk("stall_pcout", PCOut, 1);
            chk("stall_pc", InstAddress, 2);
        end
        Ready = 1'b1;
        wait_done("stall");

        // Absolute branch while PCOut=1
        push(9'd1, 10'd0); push(9'd55, 10'd10); push(HALT, 10'd11);
        pulse_start();
        tick();
        tick();
        Ready = 1'b0; BranchEn = 1'b1; BranchRel = 1'b0; Target = 10'd10;
        tick();
        BranchEn = 1'b0; Ready = 1'b1;
        chk("abs_flush_valid", Valid, 0);
        chk("abs_pc", InstAddress, 10);
        wait_done("abs");

        // Relative branch with wrap: 2 + (-3) = 1023, then PC wraps to 0
        push(9'd1, 10'd0); push(9'd7, 10'd1023);
        seq_program();
        pulse_start();
        tick();
        tick();
        Ready = 1'b0; BranchEn = 1'b1; BranchRel = 1'b1; BranchBase = 10'd2;
        Target = 10'd1021;
        tick();
        BranchEn = 1'b0; BranchRel = 1'b0; Ready = 1'b1;
        chk("rel_pc", InstAddress, 1023);
        tick();
        chk("rel_wrap_pc", InstAddress, 0);
        wait_done("rel");

        // Branch on the same edge HALT would be captured
        push(9'd1, 10'd0); push(9'd2, 10'd1); push(9'd55, 10'd10); push(HALT, 10'd11);
        pulse_start();
        tick();
        tick();
        tick();
        Ready = 1'b0; BranchEn = 1'b1; Target = 10'd10;
        chk("coll_pre_pc", InstAddress, 3);
        tick();
        BranchEn = 1'b0; Ready = 1'b1;
        chk("coll_valid", Valid, 0);
        chk("coll_done", Done, 0);
        chk("coll_pc", InstAddress, 10);
        wait_done("coll");

        // Async reset between edges with an instruction held
        pulse_start();
        Ready = 1'b0;
        tick();
        chk("rst_pre_valid", Valid, 1);
        #1 Reset = 1'b0;
        #1;
        chk("rst_async_valid", Valid, 0);
        chk("rst_async_pc", InstAddress, 0);
        chk("rst_async_done", Done, 0);
        chk("rst_async_pcout", PCOut, 0);
        tick();
        Reset = 1'b1; Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_idle_valid", Valid, 0);
        end
        seq_program();
        pulse_start();
        wait_done("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
